csa_accumulator: RTL



---
 rtl/csa_acc_pkg.sv | 23 ++
 rtl/csa_row.sv | 30 +++
 rtl/csa_accumulator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/csa_acc_pkg.sv
// csa_acc_pkg
// Shared definitions for the carry-save frame accumulator:
//   - acc_state_e : controller states (ACCUM, RESOLVE, DONE)
//   - DEF_W       : default operand width
//   - DEF_ACC_W   : default accumulator / result width
//   - maj3        : single-bit majority, i.e. the carry of a full adder
package csa_acc_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } acc_state_e;

   localparam int DEF_W     = 4;
   localparam int DEF_ACC_W = 8;

   // Majority of three bits; this is the carry-out of a full adder.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/csa_row.sv
// csa_row
// Combinational N-bit 3:2 compressor row, built from N independent full adders.
// The carry vector is returned unshifted: cy[i] carries weight 2^(i+1), so the
// caller must shift it left before using it as an operand.
// Ports:
//   a, b, c : in  [N-1:0] the three addends
//   s       : out [N-1:0] bitwise sum (a ^ b ^ c)
//   cy      : out [N-1:0] bitwise majority (the carries, unshifted)
module csa_row
   import csa_acc_pkg::*;
#(
   parameter int N = DEF_ACC_W
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   output logic [N-1:0] s,
   output logic [N-1:0] cy
);

   // One full adder per bit position; no carry ripples between positions.
   always_comb begin
      s  = a ^ b ^ c;
      cy = '0;
      for (int i = 0; i < N; i++) begin
         cy[i] = maj3(a[i], b[i], c[i]);
      end
   end

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator
// Streaming multi-operand accumulator. Each accepted beat is folded into a
// redundant (sum, carry) pair with one 3:2 compression. On the last beat of a
// frame the pair is resolved to binary by a bit-serial ripple (one bit per
// clock), then the result is presented on an output handshake.
// Build option: define CSA_ACC_SAT_EN to saturate out_sum to all ones whenever
// out_ov is set; otherwise out_sum is the total modulo 2^ACC_W.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake
//   in_data [W-1:0]       : unsigned operand (zero-extended to ACC_W)
//   in_last               : marks the final beat of a frame
//   out_valid / out_ready : result handshake
//   out_sum [ACC_W-1:0]   : frame total (wrapped, or saturated if enabled)
//   out_ov                : frame total exceeded 2^ACC_W-1
module csa_accumulator
   import csa_acc_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ov
);

   localparam int IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] s_q, s_d;
   logic [ACC_W-1:0] c_q, c_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             cy_q, cy_d;
   logic [ACC_W-1:0] res_q, res_d;
   logic             ov_q, ov_d;

   logic [ACC_W-1:0] x;
   logic [ACC_W-1:0] row_s;
   logic [ACC_W-1:0] row_cy;
   logic             beat_acc;
   logic             out_hs;
   logic             last_bit;
   logic             fa_s;
   logic             fa_c;

   assign x        = ACC_W'(in_data);
   assign beat_acc = in_valid & in_ready;
   assign out_hs   = out_valid & out_ready;
   assign last_bit = (idx_q == IDX_W'(ACC_W - 1));

   csa_row #(.N(ACC_W)) u_row (
      .a  (s_q),
      .b  (c_q),
      .c  (x),
      .s  (row_s),
      .cy (row_cy)
   );

   // Single-bit full adder for the serial resolve of bit idx_q.
   always_comb begin
      fa_s = s_q[idx_q] ^ c_q[idx_q] ^ cy_q;
      fa_c = maj3(s_q[idx_q], c_q[idx_q], cy_q);
   end

   // All state, cleared asynchronously so an abort leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         s_q     <= '0;
         c_q     <= '0;
         idx_q   <= '0;
         cy_q    <= 1'b0;
         res_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
         cy_q    <= cy_d;
         res_q   <= res_d;
         ov_q    <= ov_d;
      end
   end

   // Next-state logic for the frame controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (beat_acc && in_last) state_d = RESOLVE;
         RESOLVE: if (last_bit)            state_d = DONE;
         DONE:    if (out_hs)              state_d = ACCUM;
         default:                          state_d = ACCUM;
      endcase
   end

   // Handshake outputs decoded from the state; out_sum optionally saturates.
   always_comb begin
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == DONE);
      out_ov    = ov_q;
`ifdef CSA_ACC_SAT_EN
      out_sum   = ov_q ? '1 : res_q;
`else
      out_sum   = res_q;
`endif
   end

   // Datapath: compress each beat into (S, C); then ripple S + C one bit per
   // cycle into the result. The top carry of each compression has weight
   // 2^ACC_W, so it is dropped from C and only recorded in the sticky flag.
   always_comb begin
      s_d   = s_q;
      c_d   = c_q;
      idx_d = idx_q;
      cy_d  = cy_q;
      res_d = res_q;
      ov_d  = ov_q;
      case (state_q)
         ACCUM: begin
            if (beat_acc) begin
               s_d = row_s;
               c_d = row_cy << 1;
               if (row_cy[ACC_W-1]) ov_d = 1'b1;
               if (in_last) begin
                  idx_d = '0;
                  cy_d  = 1'b0;
               end
            end
         end
         RESOLVE: begin
            res_d[idx_q] = fa_s;
            cy_d         = fa_c;
            idx_d        = idx_q + IDX_W'(1);
            if (last_bit) ov_d = ov_q | fa_c;
         end
         DONE: begin
            if (out_hs) begin
               s_d  = '0;
               c_d  = '0;
               ov_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule
